// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ requesters: it sequences
// the tx_start/tx_busy handshake, latches the granted byte and times out a silent transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic                        active,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        err_timeout
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_ACCEPT, S_WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               active_q, active_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0] req_bytes [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Candidate order is ptr+1, ptr+2, ... with wrap; the extra bit holds ptr+i before the wrap.
    logic            found;
    logic [ID_W-1:0] win;
    always_comb begin
        logic [ID_W:0]   cand_w;
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        win    = '0;
        cand_w = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_w = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand_w >= (ID_W+1)'(NUM_REQ)) cand_w = cand_w - (ID_W+1)'(NUM_REQ);
            cand = cand_w[ID_W-1:0];
            if (!found && |(req & (NUM_REQ'(1) << cand))) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found && !tx_busy) begin
                    state_d    = S_START;
                    tx_start_d = 1'b1;
                    tx_data_d  = req_bytes[win];
                    grant_d    = win;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                // Busy wins over the timeout when both land on the last allowed cycle.
                if (tx_busy) begin
                    ack_d   = NUM_REQ'(1) << grant_q;
                    ptr_d   = grant_q;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = grant_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            active_q   <= 1'b0;
            grant_q    <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            active_q   <= active_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign active      = active_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;
endmodule
